// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Forwarding selects, FSM states and register constants.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    HZ_RUN,
    HZ_WAIT
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_fwd.sv
// Per-operand EX forwarding select.
// The younger MEM result wins over WB.
module hazard_fwd
  import hazard_pkg::*;
(
  input  logic [4:0] RS,
  input  logic [4:0] RD_MEM,
  input  logic       REGWRITE_MEM,
  input  logic [4:0] RD_WB,
  input  logic       REGWRITE_WB,
  output logic [1:0] FWD
);

  logic hit_mem;
  logic hit_wb;

  assign hit_mem = REGWRITE_MEM &&
                   (RD_MEM != REG_ZERO) &&
                   (RD_MEM == RS);
  assign hit_wb  = REGWRITE_WB &&
                   (RD_WB != REG_ZERO) &&
                   (RD_WB == RS);

  always_comb begin
    FWD = FWD_NONE;
    if (hit_mem)     FWD = FWD_MEM;
    else if (hit_wb) FWD = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: stall, flush, freeze,
// forwarding, wait-state timeout and stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic [4:0]       RS1_EX,
  input  logic [4:0]       RS2_EX,
  input  logic [4:0]       RD_EX,
  input  logic             REGWRITE_EX,
  input  logic             MEMREAD_EX,
  input  logic [4:0]       RD_MEM,
  input  logic             REGWRITE_MEM,
  input  logic [4:0]       RD_WB,
  input  logic             REGWRITE_WB,
  input  logic             BRANCHTAKEN_EX,
  input  logic             DMEM_REQ_MEM,
  input  logic             DMEM_READY,
  output logic             STALL,
  output logic             FLUSH_ID,
  output logic             FLUSH_EX,
  output logic             FREEZE,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             MEM_ERR,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam int TW = $clog2(TIMEOUT + 1);

  hz_state_e         state, state_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic [1:0]        fwd_a_raw, fwd_b_raw;
  logic              wt, lu, err_set;
  logic              unused_rw_ex;

  assign unused_rw_ex = REGWRITE_EX;

  hazard_fwd u_fwd_a (
    .RS           (RS1_EX),
    .RD_MEM       (RD_MEM),
    .REGWRITE_MEM (REGWRITE_MEM),
    .RD_WB        (RD_WB),
    .REGWRITE_WB  (REGWRITE_WB),
    .FWD          (fwd_a_raw)
  );

  hazard_fwd u_fwd_b (
    .RS           (RS2_EX),
    .RD_MEM       (RD_MEM),
    .REGWRITE_MEM (REGWRITE_MEM),
    .RD_WB        (RD_WB),
    .REGWRITE_WB  (REGWRITE_WB),
    .FWD          (fwd_b_raw)
  );

  assign wt = DMEM_REQ_MEM && !DMEM_READY;
  assign lu = MEMREAD_EX && (RD_EX != REG_ZERO) &&
              ((RD_EX == RS1_ID) || (RD_EX == RS2_ID));
  assign err_set = wt && (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    unique case (state)
      HZ_RUN: begin
        if (wt) begin
          state_nx = HZ_WAIT;
          timer_nx = TW'(1);
        end
      end
      HZ_WAIT: begin
        if (!wt) begin
          state_nx = HZ_RUN;
          timer_nx = '0;
        end else if (timer != TW'(TIMEOUT)) begin
          timer_nx = timer + TW'(1);
        end
      end
      default: begin
        state_nx = HZ_RUN;
        timer_nx = '0;
      end
    endcase
  end

  // Freeze outranks flush, which outranks the load-use stall.
  always_comb begin
    STALL    = 1'b0;
    FLUSH_ID = 1'b0;
    FLUSH_EX = 1'b0;
    FREEZE   = 1'b0;
    FWD_A    = fwd_a_raw;
    FWD_B    = fwd_b_raw;
    if (reset) begin
      FLUSH_ID = 1'b1;
      FLUSH_EX = 1'b1;
      FWD_A    = FWD_NONE;
      FWD_B    = FWD_NONE;
    end else if (wt || MEM_ERR) begin
      FREEZE = 1'b1;
    end else if (BRANCHTAKEN_EX) begin
      FLUSH_ID = 1'b1;
      FLUSH_EX = 1'b1;
    end else if (lu) begin
      STALL = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HZ_RUN;
      timer     <= '0;
      MEM_ERR   <= 1'b0;
      STALL_CNT <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      if (err_set) MEM_ERR <= 1'b1;
      if ((STALL || FREEZE) && (STALL_CNT != '1))
        STALL_CNT <= STALL_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cases
// plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 5;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] RS1_ID, RS2_ID, RS1_EX, RS2_EX;
  logic [4:0] RD_EX, RD_MEM, RD_WB;
  logic REGWRITE_EX, MEMREAD_EX, REGWRITE_MEM, REGWRITE_WB;
  logic BRANCHTAKEN_EX, DMEM_REQ_MEM, DMEM_READY;
  logic STALL, FLUSH_ID, FLUSH_EX, FREEZE, MEM_ERR;
  logic [1:0] FWD_A, FWD_B;
  logic [CNT_W-1:0] STALL_CNT;

  int checks = 0;
  int failures = 0;
  bit mon_on = 1'b0;

  int m_wc;
  bit m_err;
  int m_cnt;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .RS1_EX(RS1_EX), .RS2_EX(RS2_EX),
    .RD_EX(RD_EX), .REGWRITE_EX(REGWRITE_EX),
    .MEMREAD_EX(MEMREAD_EX),
    .RD_MEM(RD_MEM), .REGWRITE_MEM(REGWRITE_MEM),
    .RD_WB(RD_WB), .REGWRITE_WB(REGWRITE_WB),
    .BRANCHTAKEN_EX(BRANCHTAKEN_EX),
    .DMEM_REQ_MEM(DMEM_REQ_MEM), .DMEM_READY(DMEM_READY),
    .STALL(STALL), .FLUSH_ID(FLUSH_ID), .FLUSH_EX(FLUSH_EX),
    .FREEZE(FREEZE), .FWD_A(FWD_A), .FWD_B(FWD_B),
    .MEM_ERR(MEM_ERR), .STALL_CNT(STALL_CNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fwd(input logic [4:0] rs);
    if (reset) return 0;
    if (REGWRITE_MEM && RD_MEM != 0 && RD_MEM == rs) return 2;
    if (REGWRITE_WB && RD_WB != 0 && RD_WB == rs) return 1;
    return 0;
  endfunction

  // {stall, flush_id, flush_ex, freeze}
  function automatic logic [3:0] ctl();
    bit wt, lu;
    wt = DMEM_REQ_MEM && !DMEM_READY;
    lu = MEMREAD_EX && RD_EX != 0 &&
         (RD_EX == RS1_ID || RD_EX == RS2_ID);
    if (reset) return 4'b0110;
    if (wt || m_err) return 4'b0001;
    if (BRANCHTAKEN_EX) return 4'b0110;
    if (lu) return 4'b1000;
    return 4'b0000;
  endfunction

  always @(posedge clk) begin
    logic [3:0] c;
    bit wt;
    c = ctl();
    wt = DMEM_REQ_MEM && !DMEM_READY;
    if (reset) begin
      m_wc  <= 0;
      m_err <= 1'b0;
      m_cnt <= 0;
    end else begin
      m_wc <= wt ? m_wc + 1 : 0;
      if (wt && m_wc + 1 >= TIMEOUT) m_err <= 1'b1;
      if ((c[3] || c[0]) && m_cnt < CMAX) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    logic [3:0] c;
    if (mon_on) begin
      c = ctl();
      chk("m_stall", int'(STALL), int'(c[3]));
      chk("m_flush_id", int'(FLUSH_ID), int'(c[2]));
      chk("m_flush_ex", int'(FLUSH_EX), int'(c[1]));
      chk("m_freeze", int'(FREEZE), int'(c[0]));
      chk("m_fwd_a", int'(FWD_A), fwd(RS1_EX));
      chk("m_fwd_b", int'(FWD_B), fwd(RS2_EX));
      chk("m_mem_err", int'(MEM_ERR), int'(m_err));
      chk("m_cnt", int'(STALL_CNT), m_cnt);
    end
  end

  task automatic idle();
    RS1_ID = 0; RS2_ID = 0; RS1_EX = 0; RS2_EX = 0;
    RD_EX = 0; RD_MEM = 0; RD_WB = 0;
    REGWRITE_EX = 0; MEMREAD_EX = 0;
    REGWRITE_MEM = 0; REGWRITE_WB = 0;
    BRANCHTAKEN_EX = 0; DMEM_REQ_MEM = 0; DMEM_READY = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc();
    mon_on = 1'b1;
    #1;
    chk("rst_flush_id", int'(FLUSH_ID), 1);
    chk("rst_flush_ex", int'(FLUSH_EX), 1);
    chk("rst_stall", int'(STALL), 0);
    chk("rst_freeze", int'(FREEZE), 0);
    chk("rst_cnt", int'(STALL_CNT), 0);
    chk("rst_err", int'(MEM_ERR), 0);
    reset = 1'b0;
    cyc();

    RD_MEM = 5; REGWRITE_MEM = 1; RD_WB = 5; REGWRITE_WB = 1;
    RS1_EX = 5; RS2_EX = 5;
    #1;
    chk("fwd_mem_a", int'(FWD_A), 2);
    chk("fwd_mem_b", int'(FWD_B), 2);
    RD_MEM = 0;
    #1;
    chk("fwd_wb_a", int'(FWD_A), 1);
    cyc();
    idle();

    MEMREAD_EX = 1; RD_EX = 7; RS2_ID = 7;
    #1;
    chk("lu_stall", int'(STALL), 1);
    cyc();
    idle();
    #1;
    chk("lu_release", int'(STALL), 0);
    chk("lu_cnt", int'(STALL_CNT), 1);

    MEMREAD_EX = 1; RD_EX = 7; RS1_ID = 7; BRANCHTAKEN_EX = 1;
    #1;
    chk("br_lu_fid", int'(FLUSH_ID), 1);
    chk("br_lu_fex", int'(FLUSH_EX), 1);
    chk("br_lu_stall", int'(STALL), 0);
    cyc();
    idle();

    do_reset();
    DMEM_REQ_MEM = 1; DMEM_READY = 0; BRANCHTAKEN_EX = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wt_freeze", int'(FREEZE), 1);
      chk("wt_noflush", int'(FLUSH_ID), 0);
      cyc();
    end
    DMEM_READY = 1;
    #1;
    chk("wt_rel_freeze", int'(FREEZE), 0);
    chk("wt_rel_flush", int'(FLUSH_EX), 1);
    chk("wt_cnt3", int'(STALL_CNT), 3);
    cyc();
    idle();

    do_reset();
    DMEM_REQ_MEM = 1; DMEM_READY = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 2) chk("to_err_3", int'(MEM_ERR), 0);
      if (i == 3) chk("to_err_4", int'(MEM_ERR), 1);
    end
    DMEM_READY = 1;
    cyc();
    idle();
    cyc();
    chk("to_sticky", int'(MEM_ERR), 1);

    do_reset();
    chk("to_cleared", int'(MEM_ERR), 0);
    DMEM_REQ_MEM = 1; DMEM_READY = 0;
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk("rmw_fid", int'(FLUSH_ID), 1);
    chk("rmw_fex", int'(FLUSH_EX), 1);
    chk("rmw_freeze", int'(FREEZE), 0);
    cyc();
    chk("rmw_cnt", int'(STALL_CNT), 0);
    chk("rmw_err", int'(MEM_ERR), 0);
    reset = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) cyc();
    chk("rmw_timer_restart", int'(MEM_ERR), 0);
    idle();
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      RS1_ID = 5'($urandom_range(0, 3));
      RS2_ID = 5'($urandom_range(0, 3));
      RS1_EX = 5'($urandom_range(0, 3));
      RS2_EX = 5'($urandom_range(0, 3));
      RD_EX = 5'($urandom_range(0, 3));
      RD_MEM = 5'($urandom_range(0, 3));
      RD_WB = 5'($urandom_range(0, 3));
      REGWRITE_EX = 1'($urandom);
      MEMREAD_EX = 1'($urandom);
      REGWRITE_MEM = 1'($urandom);
      REGWRITE_WB = 1'($urandom);
      BRANCHTAKEN_EX = ($urandom_range(0, 3) == 0);
      DMEM_REQ_MEM = ($urandom_range(0, 2) == 0);
      DMEM_READY = ($urandom_range(0, 3) != 0);
      cyc();
    end

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central hazard controller for the 5-stage pipelined RISC-V core. It detects load-use hazards, redirect flushes from taken branches and jumps, and data-memory wait states. It drives the front-end stall, the IF/ID and ID/EX flushes, a global freeze, and the EX-stage forwarding selects. Its `STALL` output is the stall input of the ID-stage control-zeroing mux, which turns the stalled slot into a bubble. It also keeps a stall-cycle counter and a sticky memory-timeout flag for debug.

## Interface
- `TIMEOUT`, 64: consecutive wait cycles before `MEM_ERR` sets; must be ≥2.
- `CNT_W`, 16: width of `STALL_CNT`.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `RS1_ID`, `RS2_ID` in 5: source registers of the instruction in ID.
- `RS1_EX`, `RS2_EX` in 5: source registers of the instruction in EX.
- `RD_EX` in 5, `REGWRITE_EX` in 1, `MEMREAD_EX` in 1: EX-stage destination and controls.
- `RD_MEM` in 5, `REGWRITE_MEM` in 1: MEM-stage destination and write enable.
- `RD_WB` in 5, `REGWRITE_WB` in 1: WB-stage destination and write enable.
- `BRANCHTAKEN_EX` in 1: taken branch or jump resolved in EX.
- `DMEM_REQ_MEM` in 1: MEM-stage instruction accesses data memory.
- `DMEM_READY` in 1: data memory completes the access this cycle.
- `STALL` out 1: hold PC and IF/ID; zero ID controls.
- `FLUSH_ID` out 1: clear IF/ID.
- `FLUSH_EX` out 1: clear ID/EX.
- `FREEZE` out 1: hold all pipeline registers and PC.
- `FWD_A`, `FWD_B` out 2: EX operand selects.
- `MEM_ERR` out 1: sticky timeout flag.
- `STALL_CNT` out `CNT_W`: saturating count of `STALL` and `FREEZE` cycles.

## Operation
- **Forwarding** (per operand, RS1_EX→`FWD_A`, RS2_EX→`FWD_B`), combinational:
  - `10` (MEM) if `REGWRITE_MEM` and `RD_MEM`≠0 and `RD_MEM`==RS.
  - else `01` (WB) if `REGWRITE_WB` and `RD_WB`≠0 and `RD_WB`==RS.
  - else `00`. MEM wins over WB.
- **Load-use**: `lu` = `MEMREAD_EX` and `RD_EX`≠0 and (`RD_EX`==`RS1_ID` or `RD_EX`==`RS2_ID`). False rs2 matches on I-type instructions are accepted.
- **Wait condition**: `wt` = `DMEM_REQ_MEM` and not `DMEM_READY`.
- **Output priority**, highest first:
  1. `wt`: `FREEZE`=1 and `STALL`/`FLUSH_ID`/`FLUSH_EX`=0. A frozen branch or load-use is re-evaluated after the freeze releases.
  2. `BRANCHTAKEN_EX`: `FLUSH_ID`=`FLUSH_EX`=1 and `STALL`=0. The flush beats `lu`, because the dependent instruction in ID is discarded.
  3. `lu`: `STALL`=1.
- **FSM** states RUN and WAIT:
  - RUN→WAIT when `wt`; the wait timer loads 1.
  - WAIT→RUN when not `wt`, either on `DMEM_READY` or when `DMEM_REQ_MEM` drops. The timer clears.
  - WAIT→WAIT while `wt`; the timer increments, saturating at `TIMEOUT`.
  - `MEM_ERR` sets when the timer equals `TIMEOUT`-1 and `wt` holds. It stays set until `reset`. `FREEZE` continues while `MEM_ERR` is set.
- **`STALL_CNT`**: +1 on every cycle where `STALL` or `FREEZE` is 1; saturates at all-ones.

## Timing
- **Reset** (sync, active-high): state RUN, timer 0, `MEM_ERR`=0, `STALL_CNT`=0. While `reset` is high, `FLUSH_ID`=`FLUSH_EX`=1, `STALL`=`FREEZE`=0, `FWD_A`=`FWD_B`=`00`. Reset mid-wait returns to RUN on the next edge.
- **Combinational outputs**: all stall, flush and forwarding outputs decode from current inputs with zero-cycle latency.
- **Load-use**: `STALL` is exactly one cycle per dependent load. The load advances to MEM on that edge and the WB/MEM forward covers the dependency.
- **Wait states**: `FREEZE` is high on every cycle with `wt`, including the first miss cycle. It falls in the cycle `DMEM_READY` rises.
- **Counter updates**: `MEM_ERR` and `STALL_CNT` update on the rising edge after the qualifying cycle.
- **Simultaneous events**: a branch in EX together with a wait in MEM means freeze first and flush on the first non-wait cycle.

## Structure
- **`hazard_pkg`**:
  - `fwd_sel_e` = {`FWD_NONE`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10}.
  - `hz_state_e` = {`HZ_RUN`, `HZ_WAIT`}.
  - `REG_ZERO`=5'd0.
- **Sub-module**: one combinational `hazard_fwd`, instantiated twice, one per operand. The FSM, timer and counter live in the top module.

## Test plan
- **MEM forward**: `RD_MEM`=5, `REGWRITE_MEM`=1, `RD_WB`=5, `REGWRITE_WB`=1, `RS1_EX`=5 → `FWD_A`=`10`. Set `RD_MEM`=0 → `FWD_A`=`01`.
- **Load-use**: `MEMREAD_EX`=1, `RD_EX`=7, `RS2_ID`=7 → `STALL`=1 for one cycle. Next cycle `STALL`=0 and `STALL_CNT`=1.
- **Branch beats load-use**: branch plus load-use in the same cycle → `FLUSH_ID`=`FLUSH_EX`=1, `STALL`=0.
- **Three wait cycles**: `DMEM_REQ_MEM`=1 with `DMEM_READY` low for 3 cycles → `FREEZE`=1 for 3 cycles, state RUN after, `STALL_CNT`=3. Assert `BRANCHTAKEN_EX` during the wait → flush only after the freeze releases.
- **Timeout**: `TIMEOUT`=4, `DMEM_READY` held low for 6 cycles → `MEM_ERR`=1 after the 4th wait cycle. It stays 1 after ready and clears only on `reset`.
- **Reset mid-wait**: assert `reset` in WAIT → next cycle RUN, `STALL_CNT`=0, `MEM_ERR`=0, both flushes high while `reset` is held.
